// File: rtl/prim_arbiter_rr_buf.sv
// N-port arbiter (round-robin or fixed priority) feeding a single-entry
// registered output buffer with ready/valid handshake.
module prim_arbiter_rr_buf #(
    parameter int unsigned N          = 8,
    parameter int unsigned DW         = 32,
    parameter bit          EnDataPort = 1'b1,
    parameter bit          RoundRobin = 1'b1,
    localparam int unsigned IdxW      = $clog2(N)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [N-1:0]        req_i,
    input  logic [DW-1:0]       data_i [N],
    input  logic                ready_i,
    output logic [N-1:0]        gnt_o,
    output logic [IdxW-1:0]     idx_o,
    output logic                valid_o,
    output logic [DW-1:0]       data_o
);

    logic [IdxW-1:0] ptr_q;
    logic [IdxW-1:0] win_idx;
    logic            found;
    logic            load_en;
    logic            grant;
    int unsigned     cand;

    assign load_en = !valid_o || ready_i;
    assign grant   = load_en && found && !rst_i;

    // Search ptr+1 .. ptr (wrapping) in round-robin mode, 0 .. N-1 in fixed mode.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = 0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = RoundRobin ? (32'(ptr_q) + 32'd1 + k) : k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && req_i[IdxW'(cand)]) begin
                found   = 1'b1;
                win_idx = IdxW'(cand);
            end
        end
    end

    always_comb begin
        gnt_o = '0;
        if (grant) begin
            gnt_o[win_idx] = 1'b1;
        end
    end

    // Output buffer; idx/data keep their last values while empty.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            idx_o   <= '0;
            data_o  <= '0;
            ptr_q   <= IdxW'(N - 1);
        end else if (load_en) begin
            valid_o <= found;
            if (found) begin
                idx_o  <= win_idx;
                data_o <= EnDataPort ? data_i[win_idx] : '0;
                if (RoundRobin) begin
                    ptr_q <= win_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_prim_arbiter_rr_buf.sv
// Self-checking bench: round-robin and fixed 4-port instances share stimulus,
// plus a 5-port data-less instance under random traffic.
module tb_prim_arbiter_rr_buf;

    localparam int unsigned DW = 32;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [3:0]    req4;
    logic [DW-1:0] data4 [4];
    logic          ready4;
    logic [3:0]    gnt_rr, gnt_fx;
    logic [1:0]    idx_rr, idx_fx;
    logic          valid_rr, valid_fx;
    logic [DW-1:0] dout_rr, dout_fx;

    logic [4:0]    req5;
    logic [7:0]    data5 [5];
    logic          ready5;
    logic [4:0]    gnt5;
    logic [2:0]    idx5;
    logic          valid5;
    logic [7:0]    dout5;

    int errors = 0;
    int checks = 0;

    int          m_ptr   [2];
    bit          m_valid [2];
    int          m_idx   [2];
    logic [31:0] m_data  [2];
    ent_t        sb_rr [$];
    ent_t        sb_fx [$];
    logic [3:0]  last_gnt_rr, last_gnt_fx;

    prim_arbiter_rr_buf #(.N(4), .DW(DW), .EnDataPort(1'b1), .RoundRobin(1'b1)) u_rr (
        .clk_i(clk), .rst_i(rst), .req_i(req4), .data_i(data4), .ready_i(ready4),
        .gnt_o(gnt_rr), .idx_o(idx_rr), .valid_o(valid_rr), .data_o(dout_rr));

    prim_arbiter_rr_buf #(.N(4), .DW(DW), .EnDataPort(1'b1), .RoundRobin(1'b0)) u_fx (
        .clk_i(clk), .rst_i(rst), .req_i(req4), .data_i(data4), .ready_i(ready4),
        .gnt_o(gnt_fx), .idx_o(idx_fx), .valid_o(valid_fx), .data_o(dout_fx));

    prim_arbiter_rr_buf #(.N(5), .DW(8), .EnDataPort(1'b0), .RoundRobin(1'b1)) u_n5 (
        .clk_i(clk), .rst_i(rst), .req_i(req5), .data_i(data5), .ready_i(ready5),
        .gnt_o(gnt5), .idx_o(idx5), .valid_o(valid5), .data_o(dout5));

    // Reference arbitration: first requester found scanning from ptr+1 (rr) or 0 (fixed).
    function automatic void arbn(input logic [31:0] req, input int n, input int ptr,
                                 input bit rr, output int w, output bit f);
        f = 1'b0;
        w = 0;
        for (int k = 0; k < n; k++) begin
            int i;
            i = rr ? (ptr + 1 + k) % n : k;
            if (!f && req[i]) begin
                f = 1'b1;
                w = i;
            end
        end
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ptr[d]   = 3;
            m_valid[d] = 1'b0;
            m_idx[d]   = 0;
            m_data[d]  = '0;
        end
        sb_rr.delete();
        sb_fx.delete();
    endtask

    // One cycle on both 4-port instances: check grant before the edge, buffer after it.
    task automatic step4(input logic [3:0] req, input logic ready);
        bit ld [2];
        bit fnd [2];
        int w;
        bit f;
        logic [3:0] eg, ag;
        logic       av;
        logic [1:0] ai;
        logic [31:0] ad;
        ent_t e;
        @(negedge clk);
        req4   = req;
        ready4 = ready;
        #1;
        for (int d = 0; d < 2; d++) begin
            ld[d] = !m_valid[d] || ready;
            arbn(32'(req), 4, m_ptr[d], d == 0, w, f);
            fnd[d] = ld[d] && f;
            eg = fnd[d] ? 4'(1 << w) : 4'b0000;
            ag = (d == 0) ? gnt_rr : gnt_fx;
            if (d == 0) last_gnt_rr = ag; else last_gnt_fx = ag;
            checks++;
            if (ag !== eg) begin
                errors++;
                $display("FAIL gnt[%0d]: got %b want %b", d, ag, eg);
            end
            if (fnd[d]) begin
                e.idx  = w;
                e.data = data4[2'(w)];
                if (d == 0) sb_rr.push_back(e); else sb_fx.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (ld[d]) begin
                if (fnd[d]) begin
                    e = (d == 0) ? sb_rr.pop_front() : sb_fx.pop_front();
                    m_valid[d] = 1'b1;
                    m_idx[d]   = e.idx;
                    m_data[d]  = e.data;
                    if (d == 0) m_ptr[d] = e.idx;
                end else begin
                    m_valid[d] = 1'b0;
                end
            end
            av = (d == 0) ? valid_rr : valid_fx;
            ai = (d == 0) ? idx_rr   : idx_fx;
            ad = (d == 0) ? dout_rr  : dout_fx;
            checks++;
            if (av !== m_valid[d]) begin
                errors++;
                $display("FAIL valid[%0d]: got %b want %b", d, av, m_valid[d]);
            end
            checks++;
            if (ai !== 2'(m_idx[d])) begin
                errors++;
                $display("FAIL idx[%0d]: got %0d want %0d", d, ai, m_idx[d]);
            end
            checks++;
            if (ad !== m_data[d]) begin
                errors++;
                $display("FAIL data[%0d]: got %h want %h", d, ad, m_data[d]);
            end
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        req4   = 4'b1111;
        ready4 = 1'b1;
        req5   = '0;
        ready5 = 1'b0;
        for (int i = 0; i < 4; i++) data4[i] = $urandom;
        for (int i = 0; i < 5; i++) data5[i] = 8'($urandom);
        repeat (2) @(negedge clk);
        checks++;
        if (gnt_rr !== 4'b0 || gnt_fx !== 4'b0) begin
            errors++;
            $display("FAIL reset_gnt: got %b/%b want 0000", gnt_rr, gnt_fx);
        end
        checks++;
        if ({valid_rr, idx_rr, dout_rr} !== '0 || {valid_fx, idx_fx, dout_fx} !== '0) begin
            errors++;
            $display("FAIL reset_out: got v=%b i=%0d d=%h want zeros", valid_rr, idx_rr, dout_rr);
        end
        req4 = 4'b0000;
        rst  = 1'b0;
        model_reset();
    endtask

    task automatic test_rr_rotation();
        logic [3:0] exp_g [5];
        logic [1:0] exp_i [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_i = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        for (int k = 0; k < 5; k++) begin
            step4(4'b1111, 1'b1);
            checks++;
            if (last_gnt_rr !== exp_g[k] || idx_rr !== exp_i[k]) begin
                errors++;
                $display("FAIL rr_rot[%0d]: got gnt=%b idx=%0d want gnt=%b idx=%0d",
                         k, last_gnt_rr, idx_rr, exp_g[k], exp_i[k]);
            end
        end
    endtask

    task automatic test_fixed();
        for (int k = 0; k < 4; k++) begin
            step4(4'b1110, 1'b1);
            checks++;
            if (last_gnt_fx !== 4'b0010 || idx_fx !== 2'd1) begin
                errors++;
                $display("FAIL fixed[%0d]: got gnt=%b idx=%0d want gnt=0010 idx=1",
                         k, last_gnt_fx, idx_fx);
            end
        end
    endtask

    task automatic test_stall();
        step4(4'b0000, 1'b1);
        data4[2] = 32'hA5A5_A5A5;
        step4(4'b0100, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step4(4'b0011, 1'b0);
            checks++;
            if (last_gnt_rr !== 4'b0 || valid_rr !== 1'b1 || idx_rr !== 2'd2 ||
                dout_rr !== 32'hA5A5_A5A5) begin
                errors++;
                $display("FAIL stall[%0d]: got gnt=%b v=%b idx=%0d d=%h want 0000 1 2 a5a5a5a5",
                         k, last_gnt_rr, valid_rr, idx_rr, dout_rr);
            end
        end
        data4[0] = 32'h1234_5678;
        step4(4'b0011, 1'b1);
        checks++;
        if (last_gnt_rr !== 4'b0001 || idx_rr !== 2'd0) begin
            errors++;
            $display("FAIL stall_release: got gnt=%b idx=%0d want 0001 0", last_gnt_rr, idx_rr);
        end
    endtask

    task automatic test_drain();
        step4(4'b0000, 1'b1);
        checks++;
        if (valid_rr !== 1'b0 || dout_rr !== 32'h1234_5678) begin
            errors++;
            $display("FAIL drain: got v=%b d=%h want 0 12345678", valid_rr, dout_rr);
        end
        for (int i = 0; i < 4; i++) data4[i] = $urandom;
        step4(4'b0000, 1'b0);
        checks++;
        if (valid_rr !== 1'b0 || idx_rr !== 2'd0 || dout_rr !== 32'h1234_5678) begin
            errors++;
            $display("FAIL drain_hold: got v=%b i=%0d d=%h want 0 0 12345678",
                     valid_rr, idx_rr, dout_rr);
        end
    endtask

    task automatic test_async_reset();
        step4(4'b1111, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (valid_rr !== 1'b0 || valid_fx !== 1'b0 || gnt_rr !== 4'b0 || gnt_fx !== 4'b0) begin
            errors++;
            $display("FAIL async_rst: got v=%b/%b gnt=%b/%b want 0 0", valid_rr, valid_fx,
                     gnt_rr, gnt_fx);
        end
        @(negedge clk);
        req4 = 4'b0000;
        rst  = 1'b0;
        model_reset();
        step4(4'b1000, 1'b1);
        checks++;
        if (last_gnt_rr !== 4'b1000 || idx_rr !== 2'd3 || valid_rr !== 1'b1) begin
            errors++;
            $display("FAIL post_rst: got gnt=%b idx=%0d v=%b want 1000 3 1",
                     last_gnt_rr, idx_rr, valid_rr);
        end
    endtask

    task automatic test_fairness();
        logic [3:0] acc;
        for (int win = 0; win < 2; win++) begin
            acc = '0;
            for (int k = 0; k < 4; k++) begin
                step4(4'b1111, 1'b1);
                acc = acc | last_gnt_rr;
            end
            checks++;
            if (acc !== 4'b1111) begin
                errors++;
                $display("FAIL fairness[%0d]: got %b want 1111", win, acc);
            end
        end
    endtask

    task automatic test_single_req();
        for (int k = 0; k < 4; k++) begin
            step4(4'b0100, 1'b1);
            checks++;
            if (last_gnt_rr !== 4'b0100) begin
                errors++;
                $display("FAIL single[%0d]: got %b want 0100", k, last_gnt_rr);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < 4; i++) data4[i] = $urandom;
            step4(4'($urandom), $urandom_range(0, 3) != 0);
        end
    endtask

    task automatic test_random_n5();
        int  p5 = 4;
        bit  v5 = 1'b0;
        int  i5 = 0;
        int  w;
        bit  f, ld;
        logic [4:0] eg;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            req5   = 5'($urandom);
            ready5 = $urandom_range(0, 3) != 0;
            for (int i = 0; i < 5; i++) data5[i] = 8'($urandom);
            #1;
            ld = !v5 || ready5;
            arbn(32'(req5), 5, p5, 1'b1, w, f);
            f  = f && ld;
            eg = f ? 5'(1 << w) : 5'b0;
            checks++;
            if (gnt5 !== eg) begin
                errors++;
                $display("FAIL n5_gnt[%0d]: got %b want %b", c, gnt5, eg);
            end
            checks++;
            if ((gnt5 & ~req5) !== 5'b0) begin
                errors++;
                $display("FAIL n5_gnt_noreq[%0d]: got %b req %b", c, gnt5, req5);
            end
            @(posedge clk);
            #1;
            if (ld) begin
                if (f) begin
                    v5 = 1'b1;
                    i5 = w;
                    p5 = w;
                end else begin
                    v5 = 1'b0;
                end
            end
            checks++;
            if (valid5 !== v5 || idx5 !== 3'(i5)) begin
                errors++;
                $display("FAIL n5_out[%0d]: got v=%b i=%0d want v=%b i=%0d", c, valid5, idx5, v5, i5);
            end
            checks++;
            if (dout5 !== 8'h00 || idx5 >= 3'd5) begin
                errors++;
                $display("FAIL n5_range[%0d]: got d=%h i=%0d want d=00 i<5", c, dout5, idx5);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rr_rotation();
        test_fixed();
        test_stall();
        test_drain();
        test_async_reset();
        test_fairness();
        test_single_req();
        test_back_to_back();
        test_random_n5();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
